// File: rtl/uart_tx_slave.sv
// uart_tx_slave: bus-slave UART transmitter (8N1, LSB first) with a small TX FIFO.
// Ports:
//   clk, rst       system clock, synchronous active-high reset
//   we_i           bus write enable, write takes effect at the clk edge
//   addr_i         bus address, only [3:2] decoded (0 CTRL, 1 STATUS, 2 BAUD, 3 TXDATA)
//   data_i         bus write data
//   data_o         combinational read data
//   tx_pin         registered serial output, idle high
//   irq_o          registered level interrupt: FIFO drained and line idle
module uart_tx_slave #(
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter logic [15:0] DEFAULT_DIV = 16'd434
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        tx_pin,
  output logic        irq_o
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  localparam logic [1:0] A_CTRL   = 2'd0;
  localparam logic [1:0] A_STATUS = 2'd1;
  localparam logic [1:0] A_BAUD   = 2'd2;
  localparam logic [1:0] A_TXDATA = 2'd3;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             tx_en;
  logic             irq_en;
  logic             overflow;
  logic [15:0]      div;

  state_t           state;
  logic [7:0]       shifter;
  logic [15:0]      bit_div;
  logic [15:0]      bit_cnt;
  logic [2:0]       bit_idx;
  logic             tail;
  logic             tx_busy;

  logic [1:0]       sel;
  logic             fifo_empty;
  logic             fifo_full;
  logic             pop;
  logic             push;
  logic             push_ok;
  logic             bit_end;
  logic             stop_end;
  logic             unused_bits;

  assign sel         = addr_i[3:2];
  assign fifo_empty  = (count == '0);
  assign fifo_full   = (count == CNT_W'(FIFO_DEPTH));
  assign pop         = (state == IDLE) & tx_en & ~fifo_empty;
  assign push        = we_i & (sel == A_TXDATA);
  // A push into a full FIFO still fits when the head leaves in the same cycle.
  assign push_ok     = push & (~fifo_full | pop);
  assign bit_end     = (bit_cnt == bit_div - 16'd1);
  // STOP holds one clock less than a bit: its last clock is the IDLE cycle,
  // so a pop there keeps back-to-back frames gapless.
  assign stop_end    = (bit_cnt == bit_div - 16'd2);
  assign unused_bits = ^{addr_i[31:4], addr_i[1:0], data_i[31:16]};

  // Register read mux
  always_comb begin
    data_o = '0;
    case (sel)
      A_CTRL:   data_o = {30'd0, irq_en, tx_en};
      A_STATUS: data_o = {24'd0, 4'(count), overflow, fifo_empty, fifo_full, tx_busy};
      A_BAUD:   data_o = {16'd0, div};
      default:  data_o = '0;
    endcase
  end

  // FIFO storage (no reset needed, guarded by count)
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= data_i[7:0];
  end

  // Control registers, FIFO pointers and overflow flag
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      tx_en    <= 1'b0;
      irq_en   <= 1'b0;
      div      <= DEFAULT_DIV;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
      if (push_ok && !pop)      count <= count + CNT_W'(1);
      else if (!push_ok && pop) count <= count - CNT_W'(1);
      if (push && fifo_full && !pop)
        overflow <= 1'b1;
      else if (we_i && sel == A_STATUS && data_i[3])
        overflow <= 1'b0;
      if (we_i && sel == A_CTRL) begin
        tx_en  <= data_i[0];
        irq_en <= data_i[1];
      end
      if (we_i && sel == A_BAUD) div <= data_i[15:0];
    end
  end

  // TX framing FSM; tx_pin trails the state by one clock
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      tx_pin  <= 1'b1;
      irq_o   <= 1'b0;
      shifter <= '0;
      bit_div <= 16'd1;
      bit_cnt <= '0;
      bit_idx <= '0;
      tail    <= 1'b0;
      tx_busy <= 1'b0;
    end else begin
      tail    <= 1'b0;
      // tx_busy covers exactly the clocks the frame occupies on tx_pin
      tx_busy <= (state != IDLE) | tail;
      irq_o   <= irq_en & fifo_empty & ~tx_busy & (state == IDLE);
      case (state)
        IDLE: begin
          tx_pin <= 1'b1;
          if (pop) begin
            shifter <= mem[rd_ptr];
            bit_div <= (div == 16'd0) ? 16'd1 : div;
            bit_cnt <= '0;
            state   <= START;
          end
        end
        START: begin
          tx_pin <= 1'b0;
          if (bit_end) begin
            bit_cnt <= '0;
            bit_idx <= '0;
            state   <= DATA;
          end else begin
            bit_cnt <= bit_cnt + 16'd1;
          end
        end
        DATA: begin
          tx_pin <= shifter[0];
          if (bit_end) begin
            bit_cnt <= '0;
            shifter <= {1'b0, shifter[7:1]};
            if (bit_idx == 3'd7) begin
              // With one clock per bit the whole stop bit is the IDLE cycle
              if (bit_div == 16'd1) begin
                state <= IDLE;
                tail  <= 1'b1;
              end else begin
                state <= STOP;
              end
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            bit_cnt <= bit_cnt + 16'd1;
          end
        end
        STOP: begin
          tx_pin <= 1'b1;
          if (stop_end) begin
            bit_cnt <= '0;
            state   <= IDLE;
            tail    <= 1'b1;
          end else begin
            bit_cnt <= bit_cnt + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_slave.sv
// Testbench for uart_tx_slave: register table, hand-timed corner cases, and
// randomized fill/drain rounds checked by a frame-decoding monitor and a byte queue model.
module tb_uart_tx_slave;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        tx_pin;
  logic        irq;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [7:0] got_q[$];
  int         start_q[$];
  int         div_q[$];
  int         frame_err = 0;
  int         mon_div   = 4;
  logic [7:0] stim[8];

  uart_tx_slave #(.FIFO_DEPTH(DEPTH), .DEFAULT_DIV(16'd434)) dut (
    .clk(clk), .rst(rst), .we_i(we), .addr_i(addr), .data_i(wdata),
    .data_o(rdata), .tx_pin(tx_pin), .irq_o(irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Line monitor: decodes 8N1 frames using the expected divisor for each frame
  initial begin : monitor
    int d;
    logic [9:0] bits;
    logic v;
    bit bad_f;
    forever begin
      @(negedge clk);
      if (tx_pin === 1'b0) begin
        d = (div_q.size() > 0) ? div_q.pop_front() : mon_div;
        start_q.push_back(cyc);
        bad_f = 1'b0;
        bits = '0;
        for (int b = 0; b < 10; b++) begin
          for (int s = 0; s < d; s++) begin
            if (b != 0 || s != 0) @(negedge clk);
            v = tx_pin;
            if (s == 0) bits[b] = v;
            else if (v !== bits[b]) bad_f = 1'b1;
          end
        end
        if (bits[0] !== 1'b0 || bits[9] !== 1'b1) bad_f = 1'b1;
        if (bad_f) frame_err++;
        got_q.push_back(bits[8:1]);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    we = 1'b1; addr = a; wdata = d;
    @(posedge clk); #1;
    we = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    we = 1'b0; addr = a;
    @(negedge clk);
    d = rdata;
  endtask

  task automatic clear_mon();
    got_q.delete(); start_q.delete(); div_q.delete(); frame_err = 0;
  endtask

  task automatic wait_frames(input int k, input int budget, input string nm);
    int t = 0;
    while (got_q.size() < k && t < budget) begin
      @(posedge clk); #1;
      t++;
    end
    chk(nm, 32'(got_q.size()), 32'(k));
  endtask

  task automatic check_gaps(input int eff, input string nm);
    int nbad = 0;
    for (int i = 1; i < start_q.size(); i++)
      if (start_q[i] - start_q[i-1] != 10 * eff) nbad++;
    chk(nm, 32'(nbad), 32'd0);
  endtask

  // Fill with tx disabled (no pops, so the drop rule is exact), then drain and check
  task automatic run_round(input int n, input int dv, input logic irqen, input string tag);
    int cnt, eff;
    logic [31:0] r, st;
    cnt = (n > DEPTH) ? DEPTH : n;
    eff = (dv == 0) ? 1 : dv;
    wr(32'h0, 32'h0);
    wr(32'h8, 32'(dv));
    for (int i = 0; i < n; i++) wr(32'hC, {24'd0, stim[i]});
    st = 32'(cnt) << 4;
    if (n > DEPTH)    st |= 32'h8;
    if (cnt == 0)     st |= 32'h4;
    if (cnt == DEPTH) st |= 32'h2;
    rd(32'h4, r);
    chk({tag, " status after fill"}, r, st);
    clear_mon();
    mon_div = eff;
    wr(32'h0, {30'd0, irqen, 1'b1});
    wait_frames(cnt, cnt * 10 * eff + 20, {tag, " frame count"});
    for (int i = 0; i < cnt; i++)
      if (i < got_q.size()) chk($sformatf("%s byte %0d", tag, i), 32'(got_q[i]), 32'(stim[i]));
    check_gaps(eff, {tag, " frame spacing"});
    chk({tag, " frame shape"}, 32'(frame_err), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    rd(32'h4, r);
    chk({tag, " status drained"}, r, (n > DEPTH) ? 32'hC : 32'h4);
    if (n > DEPTH) begin
      wr(32'h4, 32'hFFFF_FFF7);
      rd(32'h4, r);
      chk({tag, " overflow kept w/o bit3"}, r, 32'hC);
      wr(32'h4, 32'h8);
      rd(32'h4, r);
      chk({tag, " overflow cleared"}, r, 32'h4);
    end
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rexp;
  } vec_t;

  initial begin : main
    vec_t vt[10];
    logic [31:0] r;
    logic [9:0] f;
    bit ok_pin, ok_busy, ok_low;
    int d;

    vt[0] = '{1'b0, 32'h0000_0000, 32'h0,         32'h0};
    vt[1] = '{1'b0, 32'h0000_0004, 32'h0,         32'h4};
    vt[2] = '{1'b0, 32'h0000_0008, 32'h0,         32'd434};
    vt[3] = '{1'b0, 32'h0000_000C, 32'h0,         32'h0};
    vt[4] = '{1'b1, 32'h0000_0000, 32'hFFFF_FFFE, 32'h2};
    vt[5] = '{1'b1, 32'h0000_0000, 32'h0,         32'h0};
    vt[6] = '{1'b1, 32'h0000_0008, 32'hABCD_1234, 32'h1234};
    vt[7] = '{1'b1, 32'h0000_0004, 32'hFFFF_FFFF, 32'h4};
    vt[8] = '{1'b1, 32'h1234_5608, 32'h0000_0004, 32'h4};
    vt[9] = '{1'b0, 32'hFFFF_FFF4, 32'h0,         32'h4};

    rst = 1'b1; we = 1'b0; addr = '0; wdata = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset tx_pin", 32'(tx_pin), 32'd1);
    chk("reset irq", 32'(irq), 32'd0);

    // Register access table (leaves BAUD=4, CTRL=0)
    for (int i = 0; i < 10; i++) begin
      if (vt[i].we) wr(vt[i].addr, vt[i].wdata);
      rd(vt[i].addr, r);
      chk($sformatf("reg vec %0d", i), r, vt[i].rexp);
    end

    // Single byte 0xA5 at 4 clocks/bit, exact latency and waveform
    clear_mon();
    mon_div = 4;
    wr(32'h8, 32'd4);
    wr(32'h0, 32'd1);
    f = {1'b1, 8'hA5, 1'b0};
    wr(32'hC, 32'hA5);
    addr = 32'h4;
    @(negedge clk);
    chk("t2 pin idle after push", 32'(tx_pin), 32'd1);
    @(negedge clk);
    chk("t2 pin idle at pop", 32'(tx_pin), 32'd1);
    ok_pin = 1'b1; ok_busy = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (tx_pin !== f[i / 4]) ok_pin = 1'b0;
      if (rdata[0] !== 1'b1) ok_busy = 1'b0;
    end
    chk("t2 waveform", 32'(ok_pin), 32'd1);
    chk("t2 busy during frame", 32'(ok_busy), 32'd1);
    @(negedge clk);
    chk("t2 pin after frame", 32'(tx_pin), 32'd1);
    chk("t2 busy after frame", 32'(rdata[0]), 32'd0);
    wait_frames(1, 20, "t2 frame count");
    if (got_q.size() > 0) chk("t2 byte", 32'(got_q[0]), 32'hA5);

    // Overflow: five pushes into a four-entry FIFO
    for (int i = 0; i < 5; i++) stim[i] = 8'h11 + 8'(i);
    run_round(5, 4, 1'b0, "t3");

    // Push on the pop cycle of a full FIFO, five gapless frames
    clear_mon();
    mon_div = 2;
    wr(32'h0, 32'h0);
    wr(32'h8, 32'd2);
    for (int i = 0; i < 5; i++) stim[i] = 8'h31 + 8'(i * 7);
    for (int i = 0; i < 4; i++) wr(32'hC, {24'd0, stim[i]});
    wr(32'h0, 32'h1);
    wr(32'hC, {24'd0, stim[4]});
    addr = 32'h4;
    @(negedge clk);
    chk("t4 status after full push+pop", rdata, 32'h42);
    wait_frames(5, 5 * 20 + 20, "t4 frame count");
    for (int i = 0; i < 5; i++)
      if (i < got_q.size()) chk($sformatf("t4 byte %0d", i), 32'(got_q[i]), 32'(stim[i]));
    check_gaps(2, "t4 frame spacing");
    chk("t4 frame shape", 32'(frame_err), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    rd(32'h4, r);
    chk("t4 status drained", r, 32'h4);

    // IRQ: high while drained, low from push until the final stop bit ends
    clear_mon();
    d = 4;
    mon_div = d;
    wr(32'h8, 32'(d));
    wr(32'h0, 32'h3);
    @(negedge clk);
    @(negedge clk);
    chk("t5 irq with empty fifo", 32'(irq), 32'd1);
    wr(32'hC, 32'h5A);
    @(negedge clk);
    chk("t5 irq before push seen", 32'(irq), 32'd1);
    ok_low = 1'b1;
    for (int j = 0; j <= 10 * d + 1; j++) begin
      @(negedge clk);
      if (irq !== 1'b0) ok_low = 1'b0;
    end
    chk("t5 irq low through frame", 32'(ok_low), 32'd1);
    @(negedge clk);
    chk("t5 irq after frame", 32'(irq), 32'd1);
    chk("t5 byte", (got_q.size() > 0) ? 32'(got_q[0]) : 32'hFFFF, 32'h5A);

    // Randomized fill/drain rounds, divisor 0 included
    for (int rn = 0; rn < 8; rn++) begin
      for (int i = 0; i < 8; i++) stim[i] = 8'($urandom);
      run_round(int'($urandom_range(1, 6)), int'($urandom_range(0, 5)),
                1'($urandom), $sformatf("rnd%0d", rn));
    end

    // BAUD change mid-frame affects only the next frame
    wr(32'h0, 32'h1);
    wr(32'h8, 32'd4);
    clear_mon();
    div_q.push_back(4);
    div_q.push_back(8);
    stim[0] = 8'hC3; stim[1] = 8'h96;
    wr(32'hC, {24'd0, stim[0]});
    wr(32'hC, {24'd0, stim[1]});
    repeat (15) @(posedge clk);
    #1;
    wr(32'h8, 32'd8);
    wait_frames(2, 40 + 80 + 40, "t6 frame count");
    for (int i = 0; i < 2; i++)
      if (i < got_q.size()) chk($sformatf("t6 byte %0d", i), 32'(got_q[i]), 32'(stim[i]));
    chk("t6 frame shape", 32'(frame_err), 32'd0);
    chk("t6 frame1 length", (start_q.size() > 1) ? 32'(start_q[1] - start_q[0]) : 32'hFFFF, 32'd40);

    // Reset mid-frame: line returns high, FIFO flushed, nothing further sent
    repeat (4) @(posedge clk);
    #1;
    wr(32'h8, 32'd4);
    wr(32'hC, 32'h00);
    wr(32'hC, 32'hFF);
    wr(32'hC, 32'h3C);
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("t6 pin low before reset", 32'(tx_pin), 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    addr = 32'h4;
    @(negedge clk);
    chk("t6 pin after reset", 32'(tx_pin), 32'd1);
    chk("t6 status after reset", rdata, 32'h4);
    chk("t6 irq after reset", 32'(irq), 32'd0);
    ok_pin = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (tx_pin !== 1'b1) ok_pin = 1'b0;
    end
    chk("t6 line idle after reset", 32'(ok_pin), 32'd1);
    rd(32'h8, r);
    chk("t6 baud after reset", r, 32'd434);
    rd(32'h0, r);
    chk("t6 ctrl after reset", r, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
